// File: rtl/mem_bus_if_pkg.sv
// mem_bus_if_pkg: shared state enum and default widths for the memory bus interface
package mem_bus_if_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, DONE} mem_state_t;
  localparam int ADDRWIDTH = 5;
  localparam int DATAWIDTH = 8;
endpackage

// File: rtl/mem_timer.sv
// mem_timer: transaction watchdog that flags expiry once TO_CYCLES busy cycles have elapsed
module mem_timer #(
  parameter int TO_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  // count busy cycles, restarting whenever a new transaction begins
  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  end
  // the count reaches TO_CYCLES on the edge that also leaves the busy states
  assign expired_o = cnt_q == CW'(TO_CYCLES - 1);
endmodule

// File: rtl/mem_bus_if.sv
// mem_bus_if: edge-triggered bridge from level read/write strobes to a slow req/gnt memory bus; MEM_BUS_IF_TIMEOUT_EN adds a watchdog
module mem_bus_if
  import mem_bus_if_pkg::*;
#(
  parameter int AWIDTH    = ADDRWIDTH,
  parameter int DWIDTH    = DATAWIDTH,
  parameter int TO_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata,
  output logic              stall,
  output logic              done,
  output logic              bus_req,
  output logic              bus_we,
  output logic [AWIDTH-1:0] bus_addr,
  output logic [DWIDTH-1:0] bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DWIDTH-1:0] bus_rdata,
  output logic              timeout
);
  mem_state_t state_q, state_d;
  logic rd_q, wr_q, we_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q, rdata_q, rdata_d;
  logic rd_edge, wr_edge, start, busy, expired;
  assign rd_edge = mem_rd & ~rd_q;
  assign wr_edge = mem_wr & ~wr_q;
  assign start   = (state_q == IDLE) & (rd_edge | wr_edge);
  assign busy    = (state_q == REQ) | (state_q == WAIT_RD);
`ifdef MEM_BUS_IF_TIMEOUT_EN
  logic timeout_q, to_fire;
  mem_timer #(.TO_CYCLES(TO_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (start),
    .en_i     (busy),
    .expired_o(expired)
  );
  assign to_fire = expired & (((state_q == REQ) & ~bus_gnt) | ((state_q == WAIT_RD) & ~bus_rvalid));
  // timeout pulse lines up with the DONE cycle it forces
  always_ff @(posedge clk) begin
    timeout_q <= rst ? 1'b0 : to_fire;
  end
  assign timeout = timeout_q;
`else
  localparam int unused_to_cycles = TO_CYCLES;
  assign expired = 1'b0;
  assign timeout = 1'b0;
`endif
  // next state and read-data capture; a simultaneous rd/wr edge becomes a write
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: state_d = start ? REQ : IDLE;
      REQ: begin
        if (bus_gnt) state_d = we_q ? DONE : WAIT_RD;
        else if (expired) begin
          state_d = DONE;
          rdata_d = we_q ? rdata_q : '0;
        end
      end
      WAIT_RD: begin
        if (bus_rvalid) begin
          state_d = DONE;
          rdata_d = bus_rdata;
        end else if (expired) begin
          state_d = DONE;
          rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state, strobe history and request fields latched on the starting edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= mem_rd;
      wr_q    <= mem_wr;
      rdata_q <= rdata_d;
      if (start) begin
        we_q    <= wr_edge;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end
  assign rdata     = rdata_q;
  assign stall     = busy | start;
  assign done      = state_q == DONE;
  assign bus_req   = state_q == REQ;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
endmodule

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if: directed self-checking bench for mem_bus_if
module tb_mem_bus_if;
  logic       clk, rst, mem_rd, mem_wr, bus_gnt, bus_rvalid;
  logic [4:0] addr, bus_addr;
  logic [7:0] wdata, rdata, bus_wdata, bus_rdata;
  logic       stall, done, bus_req, bus_we, timeout;
  int checks = 0;
  int errors = 0;
  mem_bus_if dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .done(done), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .timeout(timeout)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic nx();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1; mem_rd = 0; mem_wr = 0; addr = 0; wdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    nx(); nx(); #1;
    chk("rst_rdata", rdata, 0); chk("rst_done", done, 0); chk("rst_req", bus_req, 0);
    chk("rst_we", bus_we, 0); chk("rst_addr", bus_addr, 0); chk("rst_wdata", bus_wdata, 0);
    chk("rst_timeout", timeout, 0); chk("rst_stall", stall, 0);
    nx(); rst = 0;
    nx(); #1 chk("idle_stall", stall, 0);
    // read: gnt one cycle after request, rvalid two cycles after gnt
    nx(); mem_rd = 1; addr = 5'h1A; #1 chk("rd_stall_edge", stall, 1); chk("rd_req_edge", bus_req, 0);
    nx(); bus_gnt = 1; #1 chk("rd_req", bus_req, 1); chk("rd_we", bus_we, 0); chk("rd_addr", bus_addr, 5'h1A); chk("rd_stall1", stall, 1);
    nx(); bus_gnt = 0; #1 chk("rd_stall2", stall, 1); chk("rd_req_drop", bus_req, 0); chk("rd_done_early", done, 0);
    nx(); bus_rvalid = 1; bus_rdata = 8'h3C; #1 chk("rd_stall3", stall, 1); chk("rd_rdata_pre", rdata, 0);
    nx(); bus_rvalid = 0; #1 chk("rd_done", done, 1); chk("rd_stall_done", stall, 0); chk("rd_rdata", rdata, 8'h3C);
    nx(); bus_rvalid = 1; bus_rdata = 8'hFF; #1 chk("rd_done_once", done, 0); chk("rd_idle_stall", stall, 0);
    nx(); bus_rvalid = 0; mem_rd = 0; #1 chk("stray_rvalid", rdata, 8'h3C); chk("stray_stall", stall, 0);
    // write: gnt after three request cycles, inputs change after latching
    nx(); mem_wr = 1; addr = 5'h05; wdata = 8'hA5; #1 chk("wr_stall_edge", stall, 1);
    nx(); addr = 5'h1F; wdata = 8'h00; #1
    chk("wr_req1", bus_req, 1); chk("wr_we1", bus_we, 1); chk("wr_addr1", bus_addr, 5'h05); chk("wr_wdata1", bus_wdata, 8'hA5);
    nx(); mem_rd = 1; #1
    chk("wr_req2", bus_req, 1); chk("wr_addr2", bus_addr, 5'h05); chk("wr_wdata2", bus_wdata, 8'hA5); chk("wr_stall2", stall, 1);
    nx(); bus_gnt = 1; #1 chk("wr_req3", bus_req, 1); chk("wr_addr3", bus_addr, 5'h05); chk("wr_wdata3", bus_wdata, 8'hA5);
    nx(); bus_gnt = 0; #1 chk("wr_done", done, 1); chk("wr_req_drop", bus_req, 0); chk("wr_rdata_kept", rdata, 8'h3C);
    nx(); #1 chk("wr_done_once", done, 0); chk("dropped_edge_stall", stall, 0);
    nx(); #1 chk("dropped_edge_req", bus_req, 0); chk("dropped_edge_stall2", stall, 0);
    nx(); mem_rd = 0; mem_wr = 0;
    // simultaneous edges: write only
    nx(); mem_rd = 1; mem_wr = 1; #1 chk("both_stall", stall, 1);
    nx(); bus_gnt = 1; #1 chk("both_req", bus_req, 1); chk("both_we", bus_we, 1);
    nx(); bus_gnt = 0; #1 chk("both_done", done, 1);
    nx(); #1 chk("both_done_once", done, 0); chk("both_no_read", stall, 0);
    nx(); #1 chk("both_no_req", bus_req, 0); chk("both_rdata", rdata, 8'h3C);
    nx(); mem_rd = 0; mem_wr = 0;
    // reset in WAIT_RD aborts without done
    nx(); mem_rd = 1; addr = 5'h0A;
    nx(); bus_gnt = 1;
    nx(); bus_gnt = 0; #1 chk("abort_wait_stall", stall, 1); chk("abort_wait_req", bus_req, 0);
    nx(); rst = 1; mem_rd = 0;
    nx(); rst = 0; #1
    chk("abort_req", bus_req, 0); chk("abort_stall", stall, 0); chk("abort_rdata", rdata, 0); chk("abort_done", done, 0);
    nx(); #1 chk("abort_no_done", done, 0); chk("abort_idle", stall, 0);
    // mem_rd held across reset release starts exactly one read
    nx(); mem_rd = 1; rst = 1;
    nx(); nx(); rst = 0; #1 chk("held_edge", stall, 1);
    nx(); bus_gnt = 1; #1 chk("held_req", bus_req, 1);
    nx(); bus_gnt = 0; bus_rvalid = 1; bus_rdata = 8'h77; #1 chk("held_wait", stall, 1);
    nx(); bus_rvalid = 0; #1 chk("held_done", done, 1); chk("held_rdata", rdata, 8'h77);
    for (int i = 0; i < 4; i++) begin
      nx(); #1 chk("held_single_stall", stall, 0); chk("held_single_done", done, 0);
    end
    // no grant ever
    nx(); mem_rd = 0;
    nx(); mem_rd = 1; addr = 5'h03;
`ifdef MEM_BUS_IF_TIMEOUT_EN
    for (int i = 1; i <= 15; i++) begin
      nx(); #1 chk("to_wait_done", done, 0); chk("to_wait_timeout", timeout, 0);
    end
    nx(); #1 chk("to_timeout", timeout, 1); chk("to_done", done, 1); chk("to_rdata", rdata, 0);
`else
    for (int i = 0; i < 20; i++) begin
      nx(); #1 chk("nogrant_stall", stall, 1); chk("nogrant_timeout", timeout, 0); chk("nogrant_done", done, 0);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_bus_if.md
MEM_BUS_IF -- requirements
Module: mem_bus_if

Interface
REQ-001 Parameter AWIDTH, default 5, address width.
REQ-002 Parameter DWIDTH, default 8, data width.
REQ-003 Parameter TO_CYCLES, default 15, timeout limit in clk cycles; used only with MEM_BUS_IF_TIMEOUT_EN.
REQ-004 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1, synchronous, active-high reset.
REQ-006 Port mem_rd, input, 1, level read strobe from control.
REQ-007 Port mem_wr, input, 1, level write strobe from control.
REQ-008 Port addr, input, AWIDTH, transaction address.
REQ-009 Port wdata, input, DWIDTH, write data.
REQ-010 Port rdata, output, DWIDTH, last captured read data.
REQ-011 Port stall, output, 1, transaction in progress; control holds its state while it is high.
REQ-012 Port done, output, 1, one-cycle completion pulse.
REQ-013 Port bus_req, bus_we, bus_addr, bus_wdata, outputs, 1/1/AWIDTH/DWIDTH, request to slow memory.
REQ-014 Port bus_gnt, bus_rvalid, bus_rdata, inputs, 1/1/DWIDTH, memory grant, read-valid, read data.
REQ-015 Port timeout, output, 1, one-cycle error pulse; tied 0 without MEM_BUS_IF_TIMEOUT_EN.

Function
REQ-016 Registered copies rd_q/wr_q SHALL detect rising edges of mem_rd/mem_wr; only a rising edge seen in IDLE starts a transaction.
REQ-017 FSM states SHALL be IDLE, REQ, WAIT_RD, DONE.
REQ-018 IDLE->REQ on a detected edge; addr, wdata and the write flag SHALL be latched on that edge, and bus_req SHALL go high the following cycle.
REQ-019 A simultaneous rising edge on mem_rd and mem_wr SHALL start a write only; the read edge is discarded.
REQ-020 REQ SHALL hold bus_req, bus_we, bus_addr and bus_wdata stable until bus_gnt is sampled high; then write->DONE, read->WAIT_RD, and bus_req drops next cycle.
REQ-021 WAIT_RD SHALL capture bus_rdata into rdata on the cycle bus_rvalid is sampled high, then go to DONE.
REQ-022 bus_rvalid outside WAIT_RD SHALL be ignored.
REQ-023 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-024 stall SHALL be high in REQ and WAIT_RD, and combinationally high in IDLE in the cycle an edge is detected; low in DONE and otherwise in IDLE.
REQ-025 Edges occurring outside IDLE SHALL be dropped; rd_q/wr_q still track the inputs.
REQ-026 rdata SHALL hold its value until the next read capture; writes do not alter it.
REQ-027 Minimum read latency SHALL be 4 cycles from edge to done (gnt and rvalid each one cycle after request); minimum write latency SHALL be 3 cycles.

Reset
REQ-028 On rst the block SHALL enter IDLE and clear rdata, rd_q, wr_q, done, timeout, bus_req, bus_we, bus_addr and bus_wdata to 0.
REQ-029 rst during REQ or WAIT_RD SHALL abort the transaction; bus_req SHALL be low the cycle after rst is sampled, with no done pulse.
REQ-030 mem_rd held high across rst deassertion SHALL start exactly one read, because rd_q resets to 0.

Configuration
REQ-031 Macro MEM_BUS_IF_TIMEOUT_EN defined: a counter clears on entering REQ and increments each cycle in REQ or WAIT_RD.
REQ-032 With the macro defined, when the counter reaches TO_CYCLES the block SHALL pulse timeout, force rdata to 0 for reads, and go to DONE (done also pulses).
REQ-033 With the macro undefined, the block SHALL wait indefinitely, contain no counter logic, and tie timeout to 0.

Structure
REQ-034 The shared typedefs package SHALL gain the enum mem_state_t (IDLE, REQ, WAIT_RD, DONE) and the constants ADDRWIDTH=5 and DATAWIDTH=8.
REQ-035 The timeout counter SHALL be a sub-module mem_timer, instantiated only under MEM_BUS_IF_TIMEOUT_EN; all other logic lives in mem_bus_if.

Verification
REQ-036 Read: mem_rd rises, addr=5'h1A, gnt 1 cycle later, rvalid 2 cycles later with bus_rdata=8'h3C -> rdata=8'h3C, done pulses once, stall high 4 cycles.
REQ-037 Write: mem_wr rises, addr=5'h05, wdata=8'hA5, gnt after 3 cycles -> bus_we=1, bus_addr=5'h05, bus_wdata=8'hA5 stable until gnt; rdata unchanged.
REQ-038 Both strobes rise in the same cycle -> exactly one write transaction, bus_we=1, no read follows.
REQ-039 rst asserted in WAIT_RD -> next cycle bus_req=0, state IDLE, rdata=8'h00, no done pulse.
REQ-040 With MEM_BUS_IF_TIMEOUT_EN and TO_CYCLES=15, read with gnt never asserted -> timeout and done pulse together 15 cycles after REQ entry, rdata=8'h00; without the macro, stall stays high.
